seq_detector_param: RTL

//   Parametrised serial bit-pattern detector; successor to the fixed "run of 1s" Mealy detector.

---
 rtl/seq_detector_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with Mealy match, registered match and fill level.
// Optional saturating match counter enabled by defining SEQ_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             count_clr,
  output logic             match,
  output logic             match_q,
  output logic [LEN_W-1:0] fill,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_in;
  logic             ovl;
  logic             accept;
  logic             unused_hist_msb;

  // A configuration load takes priority, so the bit presented with it is dropped.
  assign accept          = in_valid & ~cfg_load;
  assign cand            = {hist[PAT_W-2:0], in_bit};
  assign unused_hist_msb = hist[PAT_W-1];

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  always_comb begin
    len_in = cfg_len;
    if (cfg_len == '0) begin
      len_in = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_in = LEN_MAX;
    end
  end

  assign match = accept && (fill >= (len - LEN_W'(1))) && (((cand ^ pat) & mask) == '0);

  // Non-overlapping mode restarts the fill count after a match so a full new pattern is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= '0;
      len  <= LEN_MAX;
      ovl  <= 1'b0;
    end else if (cfg_load) begin
      pat  <= cfg_pattern;
      len  <= len_in;
      ovl  <= cfg_overlap;
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= cand;
      if (match && !ovl) begin
        fill <= '0;
      end else if (fill < LEN_MAX) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

`ifdef SEQ_MATCH_COUNT_EN
  // A clear coinciding with a match keeps that match, so the count restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= match ? CNT_W'(1) : '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`else
  logic unused_count_clr;

  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule
